reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
//  Receives issued ALU/branch/jump ops from the decoder and holds them until both operands are known.
//  Wakes operands by snooping the ALU and LSB-load result broadcasts, then dispatches one ready op per cycle to the ALU.
//  Sits between the decoder (issue side) and the ALU.
// PARAMETERS
//  RS_SIZE    16  number of entries (power of 2, >=4)
//  TAG_W      5   ROB tag width; tag 0 = "no dependency / value valid"
//  DATA_W     32  operand/imm/pc width
//  OPENUM_W   6   decoded-op enum width
// PORTS
//  clk            in   1         clock
//  rst            in   1         reset: synchronous, active-high
//  rdy            in   1         global enable; low = freeze all state
//  clr            in   1         mispredict flush
//  issue_valid    in   1         decoder issue_enable && rs_enable
//  issue_openum   in   OPENUM_W  op
//  issue_rs1_val  in   DATA_W    rs1 value (valid when issue_rs1_tag==0)
//  issue_rs1_tag  in   TAG_W     rs1 producer tag
//  issue_rs2_val  in   DATA_W    rs2 value
//  issue_rs2_tag  in   TAG_W     rs2 producer tag
//  issue_imm      in   DATA_W    immediate
//  issue_pc       in   DATA_W    instruction pc
//  issue_rob_pos  in   TAG_W     destination ROB tag
//  alu_res_valid  in   1         ALU broadcast valid
//  alu_res_tag    in   TAG_W     ALU broadcast tag
//  alu_res_val    in   DATA_W    ALU broadcast value
//  lsb_res_valid  in   1         LSB load broadcast valid
//  lsb_res_tag    in   TAG_W     LSB broadcast tag
//  lsb_res_val    in   DATA_W    LSB broadcast value
//  rs_full        out  1         registered; to ifetch, stops issue
//  alu_enable     out  1         registered; dispatch valid this cycle
//  alu_openum/alu_val1/alu_val2/alu_imm/alu_pc/alu_rob_pos  out  as above  dispatched op fields
// BEHAVIOUR
//  Reset (rst at edge): all busy bits 0; alu_enable=0; rs_full=0; other alu_* = 0.
//  Priority at each edge: rst > !rdy (hold every register) > clr > normal.
//  clr: all busy bits 0, alu_enable<=0, rs_full<=0; issue and broadcasts in that cycle are discarded.
//  Issue: when issue_valid, write into the lowest-index free entry and set busy.
//    - Same-cycle bypass: if an incoming rsN_tag!=0 matches a valid alu/lsb broadcast tag, store that value with tag 0.
//    - ALU bypass wins if both broadcasts match.
//  Wakeup: for every busy entry, a tag!=0 that matches a valid broadcast stores the value and clears the tag to 0.
//    - Both operands can wake in the same cycle.
//  Dispatch select is combinational on registered state: the lowest-index busy entry with tag1==0 && tag2==0.
//    - At the edge: alu_enable<=1, alu_* <= entry fields, busy<=0.
//    - If none is ready: alu_enable<=0 and the other alu_* hold.
//  Latency: issued at edge E -> alu_enable high after E+1 at earliest (all operands ready at issue).
//    - Broadcast at edge E wakes the entry -> dispatch after E+1.
//  Freed slot: reusable by an issue at the next edge, not at the same edge.
//  rs_full <= (busy count after this edge) >= RS_SIZE-1.
//    - The one-slot margin covers ifetch seeing rs_full one cycle late.
//  Issue with no free entry is a protocol violation: the op is dropped and the bench flags an error.
//  Tags compare as exact TAG_W equality. Broadcasts with tag 0 are ignored.
// STRUCTURE
//  Shared definitions header: TAG/DATA/OPENUM type macros, RS_SIZE, and the reserved tag-0 constant.
//    - These are the same macros the decoder and ROB use.
//  Sub-module rs_lowest_pick: RS_SIZE-bit request vector -> {found, index}.
//    - Instantiated twice: free slot (~busy) and ready slot (busy & both tags 0).
//  Entry storage: per-field register arrays in this module, with the wakeup compare loop inline.
// TESTING
//  1. Issue ADD rs1_tag=0 val=5, rs2_tag=0 val=7, rob_pos=3 -> alu_enable 1 cycle later: val1=5, val2=7, alu_rob_pos=3.
//  2. Issue with rs1_tag=4 -> held; alu broadcast tag=4 val=0x10 -> dispatch the next cycle with val1=0x10.
//  3. Issue rs2_tag=6 in the same cycle as lsb broadcast tag=6 val=0xAB -> bypass captured, dispatch after 1 cycle with val2=0xAB.
//  4. Fill 15 of 16 entries with unready ops -> rs_full=1.
//    - Broadcast wakes one, which dispatches -> rs_full=0 the following cycle.
//  5. 3 ready ops in entries 0,1,2 -> dispatched in order 0,1,2 on consecutive cycles.
//    - clr mid-sequence -> no further alu_enable, and all entries are free.
//  6. rdy=0 for 3 cycles with a ready entry -> no state change; dispatch resumes on the first rdy=1 edge.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared ROB tag / operand types and sizes for the RS block.
// Same widths as the decoder and ROB use.
package reservation_station_pkg;
  localparam int RS_SIZE  = 16;
  localparam int TAG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int OPENUM_W = 6;
  localparam int IDX_W    = $clog2(RS_SIZE);
  localparam int CNT_W    = IDX_W + 1;

  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [OPENUM_W-1:0] op_t;

  localparam tag_t TAG_NONE = '0;

  typedef struct packed {
    tag_t  tag;
    data_t val;
  } opnd_t;

  typedef struct packed {
    logic  valid;
    tag_t  tag;
    data_t val;
  } bcast_t;

  function automatic opnd_t snoop(
    opnd_t  o,
    bcast_t a,
    bcast_t l
  );
    opnd_t r;
    r = o;
    if (o.tag != TAG_NONE) begin
      if (a.valid && a.tag == o.tag) begin
        r.tag = TAG_NONE;
        r.val = a.val;
      end else if (l.valid && l.tag == o.tag) begin
        r.tag = TAG_NONE;
        r.val = l.val;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/reservation_station_if.sv
// Issue, result broadcast and dispatch bundle of the RS.
// master = decoder/ALU side, slave = reservation station.
interface reservation_station_if;
  import reservation_station_pkg::*;

  logic  issue_valid;
  op_t   issue_openum;
  data_t issue_rs1_val;
  tag_t  issue_rs1_tag;
  data_t issue_rs2_val;
  tag_t  issue_rs2_tag;
  data_t issue_imm;
  data_t issue_pc;
  tag_t  issue_rob_pos;

  logic  alu_res_valid;
  tag_t  alu_res_tag;
  data_t alu_res_val;
  logic  lsb_res_valid;
  tag_t  lsb_res_tag;
  data_t lsb_res_val;

  logic  rs_full;
  logic  alu_enable;
  op_t   alu_openum;
  data_t alu_val1;
  data_t alu_val2;
  data_t alu_imm;
  data_t alu_pc;
  tag_t  alu_rob_pos;

  modport master (
    output issue_valid, issue_openum,
    output issue_rs1_val, issue_rs1_tag,
    output issue_rs2_val, issue_rs2_tag,
    output issue_imm, issue_pc, issue_rob_pos,
    output alu_res_valid, alu_res_tag, alu_res_val,
    output lsb_res_valid, lsb_res_tag, lsb_res_val,
    input  rs_full, alu_enable, alu_openum,
    input  alu_val1, alu_val2, alu_imm,
    input  alu_pc, alu_rob_pos
  );

  modport slave (
    input  issue_valid, issue_openum,
    input  issue_rs1_val, issue_rs1_tag,
    input  issue_rs2_val, issue_rs2_tag,
    input  issue_imm, issue_pc, issue_rob_pos,
    input  alu_res_valid, alu_res_tag, alu_res_val,
    input  lsb_res_valid, lsb_res_tag, lsb_res_val,
    output rs_full, alu_enable, alu_openum,
    output alu_val1, alu_val2, alu_imm,
    output alu_pc, alu_rob_pos
  );
endinterface

// File: rtl/rs_lowest_pick.sv
// Lowest-index priority picker over a request vector.
// Used for both free-slot and ready-slot selection.
module rs_lowest_pick #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);
  // scan high to low so the lowest set bit wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end
endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: holds issued ops until operands
// arrive, then dispatches the lowest ready entry each cycle.
module reservation_station (
  input logic clk,
  input logic rst,
  input logic rdy,
  input logic clr,
  reservation_station_if.slave bus
);
  import reservation_station_pkg::*;

  logic [RS_SIZE-1:0] busy;
  op_t   op   [RS_SIZE];
  opnd_t o1   [RS_SIZE];
  opnd_t o2   [RS_SIZE];
  data_t imm  [RS_SIZE];
  data_t pc   [RS_SIZE];
  tag_t  rob  [RS_SIZE];

  opnd_t w1 [RS_SIZE];
  opnd_t w2 [RS_SIZE];
  opnd_t in1;
  opnd_t in2;
  bcast_t ab;
  bcast_t lb;

  logic [RS_SIZE-1:0] ready;
  logic               free_found;
  logic               rdy_found;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   rdy_idx;
  logic               issue_ok;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;

  logic  full;
  logic  alu_enable;
  op_t   alu_openum;
  data_t alu_val1;
  data_t alu_val2;
  data_t alu_imm;
  data_t alu_pc;
  tag_t  alu_rob_pos;

  assign ab = '{bus.alu_res_valid, bus.alu_res_tag, bus.alu_res_val};
  assign lb = '{bus.lsb_res_valid, bus.lsb_res_tag, bus.lsb_res_val};

  // operand snoop for stored entries and the incoming op
  always_comb begin
    in1 = snoop(opnd_t'{bus.issue_rs1_tag, bus.issue_rs1_val}, ab, lb);
    in2 = snoop(opnd_t'{bus.issue_rs2_tag, bus.issue_rs2_val}, ab, lb);
    for (int i = 0; i < RS_SIZE; i++) begin
      w1[i] = snoop(o1[i], ab, lb);
      w2[i] = snoop(o2[i], ab, lb);
    end
  end

  // ready vector and occupancy after this edge
  always_comb begin
    cnt = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = busy[i] && o1[i].tag == TAG_NONE
                 && o2[i].tag == TAG_NONE;
      cnt = cnt + CNT_W'(busy[i]);
    end
    issue_ok = bus.issue_valid && free_found;
    cnt_next = cnt + CNT_W'(issue_ok) - CNT_W'(rdy_found);
  end

  rs_lowest_pick #(.N(RS_SIZE)) u_free (
    .req   (~busy),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_lowest_pick #(.N(RS_SIZE)) u_ready (
    .req   (ready),
    .found (rdy_found),
    .idx   (rdy_idx)
  );

  // entry state, wakeup, dispatch and issue
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      full        <= 1'b0;
      alu_enable  <= 1'b0;
      alu_openum  <= '0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
    end else if (rdy) begin
      if (clr) begin
        busy       <= '0;
        full       <= 1'b0;
        alu_enable <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i]) begin
            o1[i] <= w1[i];
            o2[i] <= w2[i];
          end
        end
        alu_enable <= rdy_found;
        if (rdy_found) begin
          busy[rdy_idx] <= 1'b0;
          alu_openum    <= op[rdy_idx];
          alu_val1      <= o1[rdy_idx].val;
          alu_val2      <= o2[rdy_idx].val;
          alu_imm       <= imm[rdy_idx];
          alu_pc        <= pc[rdy_idx];
          alu_rob_pos   <= rob[rdy_idx];
        end
        if (issue_ok) begin
          busy[free_idx] <= 1'b1;
          op[free_idx]   <= bus.issue_openum;
          o1[free_idx]   <= in1;
          o2[free_idx]   <= in2;
          imm[free_idx]  <= bus.issue_imm;
          pc[free_idx]   <= bus.issue_pc;
          rob[free_idx]  <= bus.issue_rob_pos;
        end
        full <= cnt_next >= CNT_W'(RS_SIZE - 1);
      end
    end
  end

  assign bus.rs_full     = full;
  assign bus.alu_enable  = alu_enable;
  assign bus.alu_openum  = alu_openum;
  assign bus.alu_val1    = alu_val1;
  assign bus.alu_val2    = alu_val2;
  assign bus.alu_imm     = alu_imm;
  assign bus.alu_pc      = alu_pc;
  assign bus.alu_rob_pos = alu_rob_pos;
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios with
// literal checks plus a randomized run against a slot model.
module tb_reservation_station;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic clr;

  reservation_station_if bus ();

  reservation_station dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  typedef struct {
    bit          busy;
    logic [5:0]  op;
    logic [4:0]  t1;
    logic [31:0] v1;
    logic [4:0]  t2;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rob;
  } ent_t;

  ent_t m [16];
  logic        e_en;
  logic        e_full;
  logic [5:0]  e_op;
  logic [31:0] e_v1;
  logic [31:0] e_v2;
  logic [31:0] e_imm;
  logic [31:0] e_pc;
  logic [4:0]  e_rob;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wake(inout logic [4:0] t, inout logic [31:0] v);
    if (t != 5'd0) begin
      if (bus.alu_res_valid && bus.alu_res_tag == t) begin
        v = bus.alu_res_val;
        t = 5'd0;
      end else if (bus.lsb_res_valid && bus.lsb_res_tag == t) begin
        v = bus.lsb_res_val;
        t = 5'd0;
      end
    end
  endtask

  task automatic model_step();
    int d;
    int f;
    int cnt;
    logic [4:0]  tt;
    logic [31:0] vv;
    if (rst) begin
      foreach (m[i]) m[i].busy = 1'b0;
      e_en = 0; e_full = 0; e_op = 0; e_v1 = 0;
      e_v2 = 0; e_imm = 0; e_pc = 0; e_rob = 0;
    end else if (rdy) begin
      if (clr) begin
        foreach (m[i]) m[i].busy = 1'b0;
        e_en = 0;
        e_full = 0;
      end else begin
        d = -1;
        f = -1;
        for (int i = 15; i >= 0; i--) begin
          if (!m[i].busy) f = i;
          if (m[i].busy && m[i].t1 == 0 && m[i].t2 == 0) d = i;
        end
        for (int i = 0; i < 16; i++) begin
          if (m[i].busy) begin
            tt = m[i].t1; vv = m[i].v1; wake(tt, vv);
            m[i].t1 = tt; m[i].v1 = vv;
            tt = m[i].t2; vv = m[i].v2; wake(tt, vv);
            m[i].t2 = tt; m[i].v2 = vv;
          end
        end
        e_en = (d >= 0);
        if (d >= 0) begin
          e_op = m[d].op; e_v1 = m[d].v1; e_v2 = m[d].v2;
          e_imm = m[d].imm; e_pc = m[d].pc; e_rob = m[d].rob;
          m[d].busy = 1'b0;
        end
        if (bus.issue_valid) begin
          if (f < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL overflow: issue with no free entry");
          end else begin
            m[f].busy = 1'b1;
            m[f].op = bus.issue_openum;
            tt = bus.issue_rs1_tag; vv = bus.issue_rs1_val;
            wake(tt, vv); m[f].t1 = tt; m[f].v1 = vv;
            tt = bus.issue_rs2_tag; vv = bus.issue_rs2_val;
            wake(tt, vv); m[f].t2 = tt; m[f].v2 = vv;
            m[f].imm = bus.issue_imm;
            m[f].pc = bus.issue_pc;
            m[f].rob = bus.issue_rob_pos;
          end
        end
        cnt = 0;
        foreach (m[i]) cnt += int'(m[i].busy);
        e_full = (cnt >= 15);
      end
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_on) begin
      check("rs_full", bus.rs_full, e_full);
      check("alu_enable", bus.alu_enable, e_en);
      check("alu_openum", bus.alu_openum, e_op);
      check("alu_val1", bus.alu_val1, e_v1);
      check("alu_val2", bus.alu_val2, e_v2);
      check("alu_imm", bus.alu_imm, e_imm);
      check("alu_pc", bus.alu_pc, e_pc);
      check("alu_rob_pos", bus.alu_rob_pos, e_rob);
    end
  end

  task automatic clear_in();
    bus.issue_valid = 0; bus.issue_openum = 0;
    bus.issue_rs1_val = 0; bus.issue_rs1_tag = 0;
    bus.issue_rs2_val = 0; bus.issue_rs2_tag = 0;
    bus.issue_imm = 0; bus.issue_pc = 0; bus.issue_rob_pos = 0;
    bus.alu_res_valid = 0; bus.alu_res_tag = 0; bus.alu_res_val = 0;
    bus.lsb_res_valid = 0; bus.lsb_res_tag = 0; bus.lsb_res_val = 0;
  endtask

  task automatic drive_issue(input logic [5:0] op,
                             input logic [4:0] t1,
                             input logic [31:0] v1,
                             input logic [4:0] t2,
                             input logic [31:0] v2,
                             input logic [4:0] rob);
    bus.issue_valid = 1;
    bus.issue_openum = op;
    bus.issue_rs1_tag = t1; bus.issue_rs1_val = v1;
    bus.issue_rs2_tag = t2; bus.issue_rs2_val = v2;
    bus.issue_imm = {27'd0, rob} + 32'h100;
    bus.issue_pc = {25'd0, rob, 2'b00};
    bus.issue_rob_pos = rob;
  endtask

  initial begin
    clear_in();
    rst = 1; rdy = 1; clr = 0;
    repeat (2) @(negedge clk);
    check("rst_en", bus.alu_enable, 0);
    check("rst_full", bus.rs_full, 0);
    check("rst_rob", bus.alu_rob_pos, 0);
    chk_on = 1;
    rst = 0;

    // ready at issue: dispatch one edge later
    drive_issue(6'd1, 5'd0, 32'd5, 5'd0, 32'd7, 5'd3);
    @(negedge clk); clear_in();
    @(negedge clk);
    check("t1_en", bus.alu_enable, 1);
    check("t1_val1", bus.alu_val1, 5);
    check("t1_val2", bus.alu_val2, 7);
    check("t1_rob", bus.alu_rob_pos, 3);

    // wait on rs1 tag 4, ALU broadcast wakes it
    drive_issue(6'd2, 5'd4, 32'hdead, 5'd0, 32'd9, 5'd5);
    @(negedge clk); clear_in();
    check("t2_hold", bus.alu_enable, 0);
    bus.alu_res_valid = 1; bus.alu_res_tag = 5'd4;
    bus.alu_res_val = 32'h10;
    @(negedge clk); clear_in();
    check("t2_wake_edge", bus.alu_enable, 0);
    @(negedge clk);
    check("t2_en", bus.alu_enable, 1);
    check("t2_val1", bus.alu_val1, 32'h10);
    check("t2_val2", bus.alu_val2, 9);

    // same-cycle LSB bypass on rs2
    drive_issue(6'd3, 5'd0, 32'd1, 5'd6, 32'd0, 5'd7);
    bus.lsb_res_valid = 1; bus.lsb_res_tag = 5'd6;
    bus.lsb_res_val = 32'hab;
    @(negedge clk); clear_in();
    @(negedge clk);
    check("t3_en", bus.alu_enable, 1);
    check("t3_val2", bus.alu_val2, 32'hab);
    check("t3_rob", bus.alu_rob_pos, 7);

    // fill 15 unready entries -> full
    for (int k = 0; k < 15; k++) begin
      drive_issue(6'd4, 5'(k + 1), 32'd0, 5'd0, 32'd0, 5'(k + 1));
      @(negedge clk);
      if (k == 13) check("t4_not_full", bus.rs_full, 0);
    end
    clear_in();
    check("t4_full", bus.rs_full, 1);
    bus.alu_res_valid = 1; bus.alu_res_tag = 5'd1;
    bus.alu_res_val = 32'h55;
    @(negedge clk); clear_in();
    check("t4_full_wake", bus.rs_full, 1);
    @(negedge clk);
    check("t4_disp", bus.alu_enable, 1);
    check("t4_val1", bus.alu_val1, 32'h55);
    check("t4_unfull", bus.rs_full, 0);
    clr = 1;
    @(negedge clk); clr = 0;
    check("t4_clr_full", bus.rs_full, 0);

    // three woken together dispatch in order, then clr
    for (int k = 0; k < 3; k++) begin
      drive_issue(6'd5, 5'd9, 32'd0, 5'd0, 32'(k), 5'(10 + k));
      @(negedge clk);
    end
    clear_in();
    bus.alu_res_valid = 1; bus.alu_res_tag = 5'd9;
    bus.alu_res_val = 32'h99;
    @(negedge clk); clear_in();
    check("t5_wait", bus.alu_enable, 0);
    @(negedge clk);
    check("t5_rob0", bus.alu_rob_pos, 10);
    check("t5_v1", bus.alu_val1, 32'h99);
    @(negedge clk);
    check("t5_en1", bus.alu_enable, 1);
    check("t5_rob1", bus.alu_rob_pos, 11);
    clr = 1;
    @(negedge clk); clr = 0;
    check("t5_clr_en", bus.alu_enable, 0);
    repeat (3) begin
      @(negedge clk);
      check("t5_idle", bus.alu_enable, 0);
    end

    // freeze with a ready entry
    drive_issue(6'd6, 5'd0, 32'h21, 5'd0, 32'h22, 5'd21);
    @(negedge clk);
    rdy = 0;
    drive_issue(6'd7, 5'd0, 32'd0, 5'd0, 32'd0, 5'd30);
    repeat (3) begin
      @(negedge clk);
      check("t6_frozen", bus.alu_enable, 0);
    end
    rdy = 1; clear_in();
    @(negedge clk);
    check("t6_en", bus.alu_enable, 1);
    check("t6_rob", bus.alu_rob_pos, 21);
    @(negedge clk);
    check("t6_no_ghost", bus.alu_enable, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 63) == 0);
      bus.issue_valid = ($urandom_range(0, 2) != 0) && !e_full;
      bus.issue_openum = 6'($urandom);
      bus.issue_rs1_tag = $urandom_range(0, 1) ?
                          5'($urandom_range(1, 7)) : 5'd0;
      bus.issue_rs1_val = $urandom;
      bus.issue_rs2_tag = $urandom_range(0, 1) ?
                          5'($urandom_range(1, 7)) : 5'd0;
      bus.issue_rs2_val = $urandom;
      bus.issue_imm = $urandom;
      bus.issue_pc = $urandom;
      bus.issue_rob_pos = 5'($urandom);
      bus.alu_res_valid = 1'($urandom_range(0, 1));
      bus.alu_res_tag = 5'($urandom_range(0, 7));
      bus.alu_res_val = $urandom;
      bus.lsb_res_valid = 1'($urandom_range(0, 1));
      bus.lsb_res_tag = 5'($urandom_range(0, 7));
      bus.lsb_res_val = $urandom;
      @(negedge clk);
    end
    clear_in();
    rst = 0; rdy = 1; clr = 0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
